// File: rtl/imm_prefix_ext_pkg.sv
// Shared constants for the prefix-built immediate extender.
// Extension modes, default widths and the prefix-counter width helper.
package imm_prefix_ext_pkg;

  localparam logic EXT_ZERO = 1'b0;
  localparam logic EXT_SIGN = 1'b1;

  localparam int DEF_IMM_W      = 5;
  localparam int DEF_DATA_W     = 8;
  localparam int DEF_MAX_PREFIX = 2;

  // Counter must hold 0..max_prefix inclusive.
  function automatic int cnt_width(input int max_prefix);
    return (max_prefix < 1) ? 1 : $clog2(max_prefix + 1);
  endfunction

endpackage

// File: rtl/imm_prefix_ext_signext.sv
// Combinational sign/zero extend-or-truncate of an IN_W-bit value to OUT_W bits.
// When IN_W >= OUT_W the mode input has no effect and the value is truncated.
module signext_n
  import imm_prefix_ext_pkg::*;
#(
  parameter int IN_W  = DEF_IMM_W,
  parameter int OUT_W = DEF_DATA_W
) (
  input  logic [IN_W-1:0]  din,
  input  logic             sext,
  output logic [OUT_W-1:0] dout
);

  generate
    if (IN_W >= OUT_W) begin : g_trunc
      logic unused_bits;
      assign dout        = din[OUT_W-1:0];
      assign unused_bits = &{1'b0, sext, din};
    end else begin : g_extend
      logic fill;
      assign fill = (sext == EXT_SIGN) ? din[IN_W-1] : 1'b0;
      assign dout = {{(OUT_W - IN_W){fill}}, din};
    end
  endgenerate

endmodule

// File: rtl/imm_prefix_ext.sv
// Accumulates PREFIX immediate fields and completes them with the next non-prefix
// instruction's field, producing a registered extended immediate for execute.
module imm_prefix_ext
  import imm_prefix_ext_pkg::*;
#(
  parameter int IMM_W      = DEF_IMM_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int MAX_PREFIX = DEF_MAX_PREFIX
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              is_prefix,
  input  logic              sext,
  input  logic              flush,
  input  logic [IMM_W-1:0]  imm_in,
  output logic [DATA_W-1:0] imm_out,
  output logic              imm_valid,
  output logic              prefix_pend,
  output logic              pfx_err
);

  localparam int PREFIX_W = MAX_PREFIX * IMM_W;
  localparam int CNT_W    = cnt_width(MAX_PREFIX);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_PREFIX);

  logic [PREFIX_W-1:0] pfx_reg, pfx_next, pfx_shift;
  logic [CNT_W-1:0]    cnt_reg, cnt_next;
  logic [DATA_W-1:0]   imm_out_reg, imm_out_next;
  logic                imm_valid_reg, imm_valid_next;
  logic                pfx_err_reg, pfx_err_next;
  logic                pend_reg, pend_next;

  logic [DATA_W-1:0]   ext_res [MAX_PREFIX+1];
  logic [DATA_W-1:0]   ext_sel;

  // One extender per possible prefix count; each sees a differently sized combined value.
  generate
    for (genvar gi = 0; gi <= MAX_PREFIX; gi++) begin : g_ext
      localparam int L = (gi + 1) * IMM_W;
      logic [L-1:0] comb;
      if (gi == 0) begin : g_bare
        assign comb = imm_in;
      end else begin : g_pfx
        assign comb = {pfx_reg[gi*IMM_W-1:0], imm_in};
      end
      signext_n #(.IN_W(L), .OUT_W(DATA_W)) u_ext (
        .din  (comb),
        .sext (sext),
        .dout (ext_res[gi])
      );
    end

    if (MAX_PREFIX == 1) begin : g_shift_one
      assign pfx_shift = imm_in;
    end else begin : g_shift_many
      assign pfx_shift = {pfx_reg[PREFIX_W-IMM_W-1:0], imm_in};
    end
  endgenerate

  always_comb begin
    ext_sel = '0;
    for (int k = 0; k <= MAX_PREFIX; k++) begin
      if (cnt_reg == CNT_W'(k)) ext_sel = ext_res[k];
    end
  end

  // flush outranks en; a stalled slot holds state but drops the pulses.
  always_comb begin
    cnt_next       = cnt_reg;
    pfx_next       = pfx_reg;
    imm_out_next   = imm_out_reg;
    imm_valid_next = 1'b0;
    pfx_err_next   = 1'b0;
    if (flush) begin
      cnt_next = '0;
      pfx_next = '0;
    end else if (en) begin
      if (is_prefix) begin
        if (cnt_reg < CNT_MAX) begin
          pfx_next = pfx_shift;
          cnt_next = cnt_reg + CNT_W'(1);
        end else begin
          pfx_err_next = 1'b1;
        end
      end else begin
        imm_out_next   = ext_sel;
        imm_valid_next = 1'b1;
        cnt_next       = '0;
        pfx_next       = '0;
      end
    end
    pend_next = (cnt_next != '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg       <= '0;
      pfx_reg       <= '0;
      imm_out_reg   <= '0;
      imm_valid_reg <= 1'b0;
      pfx_err_reg   <= 1'b0;
      pend_reg      <= 1'b0;
    end else begin
      cnt_reg       <= cnt_next;
      pfx_reg       <= pfx_next;
      imm_out_reg   <= imm_out_next;
      imm_valid_reg <= imm_valid_next;
      pfx_err_reg   <= pfx_err_next;
      pend_reg      <= pend_next;
    end
  end

  assign imm_out     = imm_out_reg;
  assign imm_valid   = imm_valid_reg;
  assign prefix_pend = pend_reg;
  assign pfx_err     = pfx_err_reg;

endmodule

// File: tb/tb_imm_prefix_ext.sv
// Directed-vector bench for imm_prefix_ext at IMM_W=5, DATA_W=8, MAX_PREFIX=2.
module tb_imm_prefix_ext;

  logic       clk = 1'b0;
  logic       rst, en, is_prefix, sext, flush;
  logic [4:0] imm_in;
  logic [7:0] imm_out;
  logic       imm_valid, prefix_pend, pfx_err;

  int total = 0;
  int bad   = 0;

  imm_prefix_ext #(.IMM_W(5), .DATA_W(8), .MAX_PREFIX(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .is_prefix   (is_prefix),
    .sext        (sext),
    .flush       (flush),
    .imm_in      (imm_in),
    .imm_out     (imm_out),
    .imm_valid   (imm_valid),
    .prefix_pend (prefix_pend),
    .pfx_err     (pfx_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Apply one decode slot, clock it, and leave outputs settled 1 time unit after the edge.
  task automatic slot(input logic r, input logic e, input logic p, input logic s,
                      input logic f, input logic [4:0] imm);
    rst = r; en = e; is_prefix = p; sext = s; flush = f; imm_in = imm;
    @(posedge clk);
    #1;
    $display("slot rst=%0b en=%0b pfx=%0b sext=%0b flush=%0b imm=%02h -> out=%02h v=%0b pend=%0b err=%0b",
             r, e, p, s, f, imm, imm_out, imm_valid, prefix_pend, pfx_err);
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; is_prefix = 1'b0; sext = 1'b1; flush = 1'b0; imm_in = 5'h1F;

    // Reset held for two clocks with an active completion on the inputs.
    for (int i = 0; i < 2; i++) begin
      slot(1, 1, 0, 1, 0, 5'h1F);
      chk("rst_out",   imm_out, 8'h00);
      chk("rst_valid", imm_valid, 1'b0);
      chk("rst_pend",  prefix_pend, 1'b0);
      chk("rst_err",   pfx_err, 1'b0);
    end

    // Bare immediate, sign then zero extension.
    slot(0, 1, 0, 1, 0, 5'b10101);
    chk("bare_sext_out", imm_out, 8'hF5);
    chk("bare_sext_v",   imm_valid, 1'b1);
    slot(0, 1, 0, 0, 0, 5'b10101);
    chk("bare_zext_out", imm_out, 8'h15);
    chk("bare_zext_v",   imm_valid, 1'b1);
    slot(0, 0, 0, 1, 0, 5'b11111);
    chk("bubble_v",   imm_valid, 1'b0);
    chk("bubble_out", imm_out, 8'h15);

    // One prefix then completion: L=10, truncated.
    slot(0, 1, 1, 1, 0, 5'b00011);
    chk("p1_pend", prefix_pend, 1'b1);
    chk("p1_v",    imm_valid, 1'b0);
    slot(0, 0, 0, 1, 0, 5'b00000);
    chk("p1_stall_pend", prefix_pend, 1'b1);
    chk("p1_stall_v",    imm_valid, 1'b0);
    slot(0, 1, 0, 1, 0, 5'b10101);
    chk("p1_out",  imm_out, 8'h75);
    chk("p1_v2",   imm_valid, 1'b1);
    chk("p1_pend2", prefix_pend, 1'b0);

    // Three prefixes: the third overflows and is dropped.
    slot(0, 1, 1, 0, 0, 5'd1);
    chk("p3a_err", pfx_err, 1'b0);
    slot(0, 1, 1, 0, 0, 5'd2);
    chk("p3b_err", pfx_err, 1'b0);
    chk("p3b_pend", prefix_pend, 1'b1);
    slot(0, 1, 1, 0, 0, 5'd3);
    chk("p3c_err", pfx_err, 1'b1);
    chk("p3c_pend", prefix_pend, 1'b1);
    slot(0, 1, 0, 1, 0, 5'd0);
    chk("p3_out",  imm_out, 8'h40);
    chk("p3_v",    imm_valid, 1'b1);
    chk("p3_err",  pfx_err, 1'b0);
    chk("p3_pend", prefix_pend, 1'b0);

    // Flush beats a same-cycle completion.
    slot(0, 1, 1, 1, 0, 5'd7);
    chk("fl_pend", prefix_pend, 1'b1);
    slot(0, 1, 0, 1, 1, 5'h1F);
    chk("fl_v",    imm_valid, 1'b0);
    chk("fl_pend2", prefix_pend, 1'b0);
    chk("fl_out",  imm_out, 8'h40);
    slot(0, 1, 0, 1, 0, 5'b01111);
    chk("fl_next_out", imm_out, 8'h0F);
    chk("fl_next_v",   imm_valid, 1'b1);

    // Reset mid-accumulation loses the prefix.
    slot(0, 1, 1, 1, 0, 5'd5);
    chk("rs_pend", prefix_pend, 1'b1);
    slot(1, 1, 1, 1, 0, 5'd9);
    chk("rs_out",  imm_out, 8'h00);
    chk("rs_pend2", prefix_pend, 1'b0);
    slot(0, 1, 0, 1, 0, 5'b10000);
    chk("rs_next_out", imm_out, 8'hF0);
    chk("rs_next_v",   imm_valid, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
